// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry adder accumulator slice.
//   RCA_WIDTH       : operand/sum width; must match the external adder
//   RCA_CNT_W       : width of the per-burst operand counter
//   rca_acc_state_t : sequencer state (ACC = collecting, DONE = result held)
package rca_pkg;
    localparam int RCA_WIDTH = 5;
    localparam int RCA_CNT_W = 4;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } rca_acc_state_t;
endpackage

// File: rtl/rca_accum_seq_if.sv
// Operand-in / result-out stream bundle for rca_accum_seq.
//   in_valid/in_ready/in_data/in_last : operand stream (producer -> block)
//   out_valid/out_ready               : result handshake (block -> consumer)
//   out_sum/out_ovf/out_cnt           : burst total, sticky carry, beat count
// Modport master is the environment side, slave is the accumulator side.
interface rca_accum_seq_if
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_sum;
    logic                 out_ovf;
    logic [RCA_CNT_W-1:0] out_cnt;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_cnt
    );
endinterface

// File: rtl/rca_accum_seq.sv
// Operand sequencer and result accumulator around an external 5-bit
// ripple-carry adder. Operands arrive on bus.in_*; the adder sees
// {accumulator, operand} on add_a/add_b and its sum/carry are captured back
// into the accumulator. After N_OPS beats (or an in_last beat) the total,
// sticky carry flag and beat count are held on bus.out_* until taken.
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   bus (slave)     : operand stream in, result stream out
//   add_a, add_b    : to adder a/b (accumulator, operand pass-through)
//   add_sum, add_co : from adder sum/co
// N_OPS legal range is 1..15 (must fit the 4-bit counter).
module rca_accum_seq
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH,
    parameter int N_OPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    rca_accum_seq_if.slave   bus,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_co
);
    localparam logic [RCA_CNT_W-1:0] LAST_CNT = RCA_CNT_W'(N_OPS);

    rca_acc_state_t       state;
    logic [WIDTH-1:0]     acc;
    logic                 ovf;
    logic [RCA_CNT_W-1:0] cnt;
    logic                 in_ready_r;
    logic                 out_valid_r;

    logic                 accept;
    logic [RCA_CNT_W-1:0] cnt_nxt;
    logic                 burst_end;

    // in_ready comes straight from a flop so it never depends on in_valid.
    assign accept    = bus.in_valid && in_ready_r;
    assign cnt_nxt   = cnt + RCA_CNT_W'(1);
    // in_last and count-reached collapse into a single burst end.
    assign burst_end = bus.in_last || (cnt_nxt == LAST_CNT);

    // The accumulator feeds the adder directly; acc -> adder -> acc D-input
    // is the critical path, so nothing else sits in it.
    assign add_a = acc;
    assign add_b = bus.in_data;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
    assign bus.out_cnt   = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACC;
            acc         <= '0;
            ovf         <= 1'b0;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc <= add_sum;
                        ovf <= ovf | add_co;
                        cnt <= cnt_nxt;
                        if (burst_end) begin
                            state       <= DONE;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Result registers stay frozen until the consumer takes them.
                    if (bus.out_ready) begin
                        acc         <= '0;
                        ovf         <= 1'b0;
                        cnt         <= '0;
                        state       <= ACC;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state       <= ACC;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
